// File: rtl/sync_width_conv_fifo.sv
// sync_width_conv_fifo
// ---------------------------------------------------------------------------
// Single-clock FIFO whose write and read words may differ in width by a
// power-of-two ratio (1, 2, 4 or 8 either way). Storage is kept in units of
// N = min(write width, read width) bits, so a write stores WU units and a
// read consumes RU units. SUBWORD_ORDER selects whether the least or most
// significant slice of a wide word is the earliest narrow word.
//
// Ports
//   clk               rising-edge clock for all logic
//   rst               synchronous, active-high reset
//   i_wr_en           write request
//   i_wr_data         write word (WR_DATA_WIDTH)
//   o_wr_full         fewer than WU free units remain
//   o_almost_full     o_wr_water_level >= ALMOST_FULL_NUM
//   o_wr_water_level  occupancy in write words, rounded up
//   o_wr_overflow     one-cycle pulse after a rejected write
//   i_rd_en           read request
//   o_rd_data         registered read word (RD_DATA_WIDTH)
//   o_rd_empty        fewer than RU units stored
//   o_almost_empty    o_rd_water_level <= ALMOST_EMPTY_NUM
//   o_rd_water_level  complete read words available
//   o_rd_underflow    one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module sync_width_conv_fifo #(
    parameter int    WR_DATA_WIDTH    = 32,
    parameter int    RD_DATA_WIDTH    = 16,
    parameter int    WR_DEPTH_WIDTH   = 11,
    parameter int    ALMOST_FULL_NUM  = 1020,
    parameter int    ALMOST_EMPTY_NUM = 4,
    parameter string SUBWORD_ORDER    = "LSB_FIRST",
    localparam int N  = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH,
    localparam int WU = WR_DATA_WIDTH / N,
    localparam int RU = RD_DATA_WIDTH / N,
    localparam int C  = (1 << WR_DEPTH_WIDTH) * WU,
    localparam int PW = $clog2(C),
    localparam int RD_DEPTH_WIDTH = PW - $clog2(RU)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [WR_DATA_WIDTH-1:0]   i_wr_data,
    output logic                       o_wr_full,
    output logic                       o_almost_full,
    output logic [WR_DEPTH_WIDTH:0]    o_wr_water_level,
    output logic                       o_wr_overflow,
    input  logic                       i_rd_en,
    output logic [RD_DATA_WIDTH-1:0]   o_rd_data,
    output logic                       o_rd_empty,
    output logic                       o_almost_empty,
    output logic [RD_DEPTH_WIDTH:0]    o_rd_water_level,
    output logic                       o_rd_underflow
);

    localparam int CW    = PW + 1;
    localparam int WLW   = WR_DEPTH_WIDTH + 1;
    localparam int RLW   = RD_DEPTH_WIDTH + 1;
    localparam int WU_SH = $clog2(WU);
    localparam int RU_SH = $clog2(RU);

    localparam logic [CW-1:0] C_UNITS = CW'(C);
    localparam logic [CW-1:0] WU_U    = CW'(WU);
    localparam logic [CW-1:0] RU_U    = CW'(RU);
    localparam logic [CW-1:0] WU_M1   = CW'(WU - 1);
    localparam logic [31:0]   AF_NUM  = 32'(ALMOST_FULL_NUM);
    localparam logic [31:0]   AE_NUM  = 32'(ALMOST_EMPTY_NUM);
    localparam bit            MSB_FIRST = (SUBWORD_ORDER == "MSB_FIRST");

    logic [N-1:0]             r_mem [C];
    logic [PW-1:0]            r_wrPtr;
    logic [PW-1:0]            r_rdPtr;
    logic [CW-1:0]            r_cnt;
    logic [RD_DATA_WIDTH-1:0] r_rdData;
    logic                     r_wrOverflow;
    logic                     r_rdUnderflow;

    logic                     w_wrFull;
    logic                     w_rdEmpty;
    logic                     w_wrAccept;
    logic                     w_rdAccept;
    logic [RD_DATA_WIDTH-1:0] w_rdWord;

    // Full/empty come straight from the registered unit count, so a read in
    // the same cycle never frees space for a write (and vice versa).
    assign w_wrFull   = (C_UNITS - r_cnt) < WU_U;
    assign w_rdEmpty  = r_cnt < RU_U;
    assign w_wrAccept = i_wr_en & ~w_wrFull;
    assign w_rdAccept = i_rd_en & ~w_rdEmpty;

    // Water levels: write side rounds a partly drained word up, read side
    // only counts fully assembled words.
    assign o_wr_full        = w_wrFull;
    assign o_rd_empty       = w_rdEmpty;
    assign o_wr_water_level = WLW'((r_cnt + WU_M1) >> WU_SH);
    assign o_rd_water_level = RLW'(r_cnt >> RU_SH);
    assign o_almost_full    = 32'(o_wr_water_level) >= AF_NUM;
    assign o_almost_empty   = 32'(o_rd_water_level) <= AE_NUM;
    assign o_rd_data        = r_rdData;
    assign o_wr_overflow    = r_wrOverflow;
    assign o_rd_underflow   = r_rdUnderflow;

    // Gather RU consecutive units starting at the read pointer into one read
    // word. Unit 0 is the earliest and lands at the low or high slice
    // depending on the sub-word order.
    always_comb begin
        w_rdWord = '0;
        for (int j = 0; j < RU; j++) begin
            w_rdWord[(MSB_FIRST ? (RU - 1 - j) : j) * N +: N] = r_mem[r_rdPtr + PW'(j)];
        end
    end

    // Unit storage is never reset. An accepted write scatters its WU slices
    // into consecutive units; the write pointer is always WU-aligned so a
    // word never straddles the wrap point.
    always_ff @(posedge clk) begin
        if (!rst && w_wrAccept) begin
            for (int i = 0; i < WU; i++) begin
                r_mem[r_wrPtr + PW'(i)] <= i_wr_data[(MSB_FIRST ? (WU - 1 - i) : i) * N +: N];
            end
        end
    end

    // Pointers, unit count, read data register and the overflow/underflow
    // pulses. Both pulses reflect only the request seen at this edge, so they
    // last exactly one cycle per rejected request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_cnt         <= '0;
            r_rdData      <= '0;
            r_wrOverflow  <= 1'b0;
            r_rdUnderflow <= 1'b0;
        end else begin
            r_wrOverflow  <= i_wr_en & w_wrFull;
            r_rdUnderflow <= i_rd_en & w_rdEmpty;
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + PW'(WU);
            end
            if (w_rdAccept) begin
                r_rdPtr  <= r_rdPtr + PW'(RU);
                r_rdData <= w_rdWord;
            end
            case ({w_wrAccept, w_rdAccept})
                2'b10:   r_cnt <= r_cnt + WU_U;
                2'b01:   r_cnt <= r_cnt - RU_U;
                2'b11:   r_cnt <= r_cnt + WU_U - RU_U;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
